// File: rtl/acc_ctrl.sv
// rtl/acc_ctrl.sv - accumulator bank sequencer: fill, accumulate, drain, flag output stream
// Optional feature macro: ACC_CTRL_PERF_EN adds the perf_cycles busy-cycle counter port.
module acc_ctrl #(
  parameter int DEPTH      = 8,
  parameter int ARRAY_M    = 8,
  parameter int PASS_WIDTH = 8,
  parameter int FILL_LAT   = 8,
  parameter int DRAIN_LAT  = 1,
  localparam int CNW       = $clog2(ARRAY_M) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CNW-1:0]        cmd_num_cols,
  input  logic [PASS_WIDTH-1:0] cmd_num_passes,
  output logic                  acc_on,
  output logic [CNW-1:0]        acc_num_cols,
  output logic                  acc_drain,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
`ifdef ACC_CTRL_PERF_EN
  ,output logic [31:0]          perf_cycles
`endif
);

  // One down-counter serves every timed phase, so it must hold the longest of them.
  localparam int ON_MAX  = ((1 << PASS_WIDTH) - 1) * DEPTH + ARRAY_M - 1;
  localparam int MAX_A   = (ON_MAX > DEPTH) ? ON_MAX : DEPTH;
  localparam int MAX_B   = (MAX_A > FILL_LAT) ? MAX_A : FILL_LAT;
  localparam int CNT_MAX = (MAX_B > DRAIN_LAT) ? MAX_B : DRAIN_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ACCUM,
    S_GAP,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [PASS_WIDTH-1:0] passes_q;
  logic [CNW-1:0]        num_cols_q;
  logic                  cmd_ready_q;
  logic                  acc_on_q;
  logic                  acc_drain_q;
  logic                  drain_last_q;
  logic                  busy_q;
  logic                  done_q;

  logic [CNW-1:0]        c_clamp;
  logic [PASS_WIDTH-1:0] p_clamp;
  logic                  handshake;

  // on-cycle count minus one: P*DEPTH + C - 2, never negative since C,P >= 1
  function automatic logic [CW-1:0] on_len_m1(input logic [CNW-1:0] c,
                                              input logic [PASS_WIDTH-1:0] p);
    return CW'(p) * CW'(DEPTH) + CW'(c) - CW'(2);
  endfunction

  // Clamp the incoming command fields into their legal ranges.
  always_comb begin
    c_clamp = cmd_num_cols;
    if (cmd_num_cols == '0) begin
      c_clamp = CNW'(1);
    end else if (cmd_num_cols > CNW'(ARRAY_M)) begin
      c_clamp = CNW'(ARRAY_M);
    end
    p_clamp = cmd_num_passes;
    if (cmd_num_passes == '0) begin
      p_clamp = PASS_WIDTH'(1);
    end
  end

  assign handshake = cmd_valid && cmd_ready_q && (state_q == S_IDLE);

  // Main sequencer: state, phase counter and all registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      passes_q     <= '0;
      num_cols_q   <= '0;
      cmd_ready_q  <= 1'b0;
      acc_on_q     <= 1'b0;
      acc_drain_q  <= 1'b0;
      drain_last_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (handshake) begin
            passes_q    <= p_clamp;
            num_cols_q  <= c_clamp;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (FILL_LAT > 0) begin
              state_q <= S_FILL;
              cnt_q   <= CW'(FILL_LAT - 1);
            end else begin
              state_q  <= S_ACCUM;
              acc_on_q <= 1'b1;
              cnt_q    <= on_len_m1(c_clamp, p_clamp);
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        S_FILL: begin
          if (cnt_q == '0) begin
            state_q  <= S_ACCUM;
            acc_on_q <= 1'b1;
            cnt_q    <= on_len_m1(num_cols_q, passes_q);
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_ACCUM: begin
          if (cnt_q == '0) begin
            state_q  <= S_GAP;
            acc_on_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_GAP: begin
          state_q      <= S_DRAIN;
          acc_drain_q  <= 1'b1;
          drain_last_q <= (DEPTH == 1);
          cnt_q        <= CW'(DEPTH - 1);
        end
        S_DRAIN: begin
          if (cnt_q == '0) begin
            acc_drain_q  <= 1'b0;
            drain_last_q <= 1'b0;
            if (DRAIN_LAT > 0) begin
              state_q <= S_FLUSH;
              cnt_q   <= CW'(DRAIN_LAT - 1);
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q        <= cnt_q - CW'(1);
            drain_last_q <= (cnt_q == CW'(1));
          end
        end
        S_FLUSH: begin
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign acc_on       = acc_on_q;
  assign acc_num_cols = num_cols_q;
  assign acc_drain    = acc_drain_q;
  assign busy         = busy_q;
  assign done         = done_q;

  // out_valid/out_last follow acc_drain by the accumulator read latency.
  generate
    if (DRAIN_LAT == 0) begin : g_no_delay
      assign out_valid = acc_drain_q;
      assign out_last  = drain_last_q;
    end else begin : g_delay
      logic [DRAIN_LAT-1:0] vld_sr_q;
      logic [DRAIN_LAT-1:0] lst_sr_q;

      // Shift line; cleared on reset so in-flight beats are dropped.
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_sr_q <= '0;
          lst_sr_q <= '0;
        end else begin
          vld_sr_q[0] <= acc_drain_q;
          lst_sr_q[0] <= drain_last_q;
          for (int i = 1; i < DRAIN_LAT; i++) begin
            vld_sr_q[i] <= vld_sr_q[i-1];
            lst_sr_q[i] <= lst_sr_q[i-1];
          end
        end
      end

      assign out_valid = vld_sr_q[DRAIN_LAT-1];
      assign out_last  = lst_sr_q[DRAIN_LAT-1];
    end
  endgenerate

`ifdef ACC_CTRL_PERF_EN
  logic [31:0] perf_q;

  // Busy-cycle counter: cleared at handshake, saturating, held while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else if (handshake) begin
      perf_q <= '0;
    end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_acc_ctrl.sv
// tb/tb_acc_ctrl.sv - directed self-checking bench for acc_ctrl
module tb_acc_ctrl;

  logic clk;
  logic rst0, rst1;
  logic v0, v1;
  logic [3:0] c0, c1;
  logic [7:0] p0, p1;

  logic r0, on0, drn0, ov0, ol0, busy0, done0;
  logic r1, on1, drn1, ov1, ol1, busy1, done1;
  logic [3:0] nc0, nc1;
`ifdef ACC_CTRL_PERF_EN
  logic [31:0] perf0, perf1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] t_rdy, t_on, t_drn, t_ov, t_ol, t_busy, t_done;
  logic [3:0]   t_nc [0:127];
  logic [31:0]  t_perf [0:127];

  acc_ctrl u0 (
    .clk(clk), .reset(rst0), .cmd_valid(v0), .cmd_ready(r0),
    .cmd_num_cols(c0), .cmd_num_passes(p0), .acc_on(on0), .acc_num_cols(nc0),
    .acc_drain(drn0), .out_valid(ov0), .out_last(ol0), .busy(busy0), .done(done0)
`ifdef ACC_CTRL_PERF_EN
    , .perf_cycles(perf0)
`endif
  );

  acc_ctrl #(.FILL_LAT(0), .DRAIN_LAT(0)) u1 (
    .clk(clk), .reset(rst1), .cmd_valid(v1), .cmd_ready(r1),
    .cmd_num_cols(c1), .cmd_num_passes(p1), .acc_on(on1), .acc_num_cols(nc1),
    .acc_drain(drn1), .out_valid(ov1), .out_last(ol1), .busy(busy1), .done(done1)
`ifdef ACC_CTRL_PERF_EN
    , .perf_cycles(perf1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int first_of(input logic [127:0] v);
    for (int i = 0; i < 128; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int last_of(input logic [127:0] v);
    for (int i = 127; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int cnt_of(input logic [127:0] v, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (v[i]) n++;
    return n;
  endfunction

  // Drive one command at index 0 and record n cycles of outputs (index = cycles after handshake).
  task automatic run(input int which, input logic [3:0] c, input logic [7:0] p,
                     input int n, input int hold, input int rst_at);
    t_rdy = '0; t_on = '0; t_drn = '0; t_ov = '0; t_ol = '0; t_busy = '0; t_done = '0;
    for (int k = 0; k < n; k++) begin
      if (which == 0) begin
        v0 = (k < hold); c0 = c; p0 = p;
        if (k == rst_at) rst0 = 1'b1;
        else if (k == rst_at + 1) rst0 = 1'b0;
        t_rdy[k] = r0; t_on[k] = on0; t_drn[k] = drn0; t_ov[k] = ov0;
        t_ol[k] = ol0; t_busy[k] = busy0; t_done[k] = done0; t_nc[k] = nc0;
`ifdef ACC_CTRL_PERF_EN
        t_perf[k] = perf0;
`else
        t_perf[k] = '0;
`endif
      end else begin
        v1 = (k < hold); c1 = c; p1 = p;
        t_rdy[k] = r1; t_on[k] = on1; t_drn[k] = drn1; t_ov[k] = ov1;
        t_ol[k] = ol1; t_busy[k] = busy1; t_done[k] = done1; t_nc[k] = nc1;
`ifdef ACC_CTRL_PERF_EN
        t_perf[k] = perf1;
`else
        t_perf[k] = '0;
`endif
      end
      @(negedge clk);
    end
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic check_default_run(input string tag);
    check({tag, "_ready_T"}, t_rdy[0], 1);
    check({tag, "_ncols"}, t_nc[1], 8);
    check({tag, "_on_first"}, first_of(t_on), 9);
    check({tag, "_on_last"}, last_of(t_on), 23);
    check({tag, "_on_cnt"}, cnt_of(t_on, 0, 127), 15);
    check({tag, "_gap"}, {t_on[24], t_drn[24]}, 0);
    check({tag, "_drn_first"}, first_of(t_drn), 25);
    check({tag, "_drn_last"}, last_of(t_drn), 32);
    check({tag, "_ov_first"}, first_of(t_ov), 26);
    check({tag, "_ov_cnt"}, cnt_of(t_ov, 0, 127), 8);
    check({tag, "_ol_idx"}, first_of(t_ol), 33);
    check({tag, "_ol_cnt"}, cnt_of(t_ol & t_ov, 0, 127), 1);
    check({tag, "_done_idx"}, first_of(t_done), 34);
    check({tag, "_done_cnt"}, cnt_of(t_done, 0, 127), 1);
    check({tag, "_busy_done"}, t_busy[34], 1);
    check({tag, "_idle_after"}, {t_rdy[35], t_busy[35]}, 2'b10);
    check({tag, "_on_drn_overlap"}, cnt_of(t_on & t_drn, 0, 127), 0);
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    v0 = 1'b0; v1 = 1'b0; c0 = '0; c1 = '0; p0 = '0; p1 = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_u0_outs", {r0, on0, nc0, drn0, ov0, ol0, busy0, done0}, 0);
    check("rst_u1_outs", {r1, on1, nc1, drn1, ov1, ol1, busy1, done1}, 0);
`ifdef ACC_CTRL_PERF_EN
    check("rst_perf", perf0, 0);
`endif
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    check("ready_after_rst_u0", r0, 1);
    check("ready_after_rst_u1", r1, 1);

    // Defaults, C=8 P=1
    run(0, 4'd8, 8'd1, 40, 1, -1);
    check_default_run("dflt");
`ifdef ACC_CTRL_PERF_EN
    check("perf_after_done", t_perf[35], 34);
    check("perf_hold_idle", t_perf[39], 34);
`endif

    // C=0 P=0 behaves as C=1 P=1
    run(0, 4'd0, 8'd0, 40, 1, -1);
    check("c0p0_ncols", t_nc[1], 1);
    check("c0p0_on_cnt", cnt_of(t_on, 0, 127), 8);
    check("c0p0_on_first", first_of(t_on), 9);
    check("c0p0_drn_first", first_of(t_drn), 18);
    check("c0p0_done_idx", first_of(t_done), 27);

    // C=12 clamps to 8, P=2
    run(0, 4'd12, 8'd2, 48, 1, -1);
    check("c12_ncols", t_nc[1], 8);
    check("c12_on_cnt", cnt_of(t_on, 0, 127), 23);
    check("c12_on_last", last_of(t_on), 31);
    check("c12_done_idx", first_of(t_done), 42);
    check("c12_ncols_hold", t_nc[45], 8);

    // cmd_valid held high across two commands
    run(0, 4'd8, 8'd1, 72, 36, -1);
    check("hold_ready_mid_cnt", cnt_of(t_rdy, 1, 69), 1);
    check("hold_second_hs", first_of(t_rdy & ~128'd1), 35);
    check("hold_ov_cmd1", cnt_of(t_ov, 0, 34), 8);
    check("hold_ov_cmd2", cnt_of(t_ov, 35, 71), 8);
    check("hold_done_cnt", cnt_of(t_done, 0, 71), 2);
    check("hold_done2_idx", last_of(t_done), 69);
    check("hold_ready_end", t_rdy[70], 1);

    // Reset pulsed at cycle 15 of a default run
    run(0, 4'd8, 8'd1, 40, 1, 15);
    check("rstmid_on_before", t_on[15], 1);
    check("rstmid_outs_zero",
          {t_rdy[16], t_on[16], t_drn[16], t_ov[16], t_ol[16], t_busy[16], t_done[16]}, 0);
    check("rstmid_ncols_zero", t_nc[16], 0);
    check("rstmid_no_done", cnt_of(t_done, 0, 39), 0);
    check("rstmid_no_ov", cnt_of(t_ov, 0, 39), 0);
    check("rstmid_ready", t_rdy[17], 1);
`ifdef ACC_CTRL_PERF_EN
    check("rstmid_perf_zero", t_perf[16], 0);
`endif
    run(0, 4'd8, 8'd1, 40, 1, -1);
    check_default_run("after_rst");

    // FILL_LAT=0, DRAIN_LAT=0 instance: C=3 P=4
    run(1, 4'd3, 8'd4, 50, 1, -1);
    check("z_on_first", first_of(t_on), 1);
    check("z_on_last", last_of(t_on), 34);
    check("z_on_cnt", cnt_of(t_on, 0, 127), 34);
    check("z_drn_first", first_of(t_drn), 36);
    check("z_ov_eq_drn", cnt_of(t_ov ^ t_drn, 0, 127), 0);
    check("z_ol_idx", first_of(t_ol), 43);
    check("z_done_idx", first_of(t_done), 44);
    check("z_ready_after", t_rdy[45], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/acc_ctrl.md
# acc_ctrl

Sequencer for the output-stationary accumulator bank at the bottom of the systolic array. It accepts one tile command over a valid/ready handshake and drives the accumulator's `on`, `num_cols` and `drain` controls. It waits for the array pipeline to fill, keeps `on` high across all K-passes including column skew, then drains the bank and flags the output stream. It sits between the top-level tile scheduler and the accumulator instance.

## Interface
- `DEPTH`, 8, accumulator entries per column; also the pass stride in cycles
- `ARRAY_M`, 8, array columns
- `PASS_WIDTH`, 8, width of the pass count
- `FILL_LAT`, 8, cycles from the command handshake until the first partial sum reaches column 0; 0 is legal
- `DRAIN_LAT`, 1, cycles from `acc_drain` high to the matching data on `acc_out`; 0 is legal
- `clk` in 1, rising-edge clock
- `reset` in 1, synchronous, active-high
- `cmd_valid` in 1, command request
- `cmd_ready` out 1, high only in IDLE
- `cmd_num_cols` in $clog2(ARRAY_M)+1, active column count
- `cmd_num_passes` in PASS_WIDTH, number of K-passes
- `acc_on` out 1, drives accumulator `on`
- `acc_num_cols` out $clog2(ARRAY_M)+1, drives accumulator `num_cols`
- `acc_drain` out 1, drives accumulator `drain`
- `out_valid` out 1, `acc_out` holds valid data this cycle
- `out_last` out 1, final drained word, coincident with `out_valid`
- `busy` out 1, command in flight
- `done` out 1, one-cycle completion pulse
- `perf_cycles` out 32, present only under `ACC_CTRL_PERF_EN`

## Operation
- States: IDLE → FILL → ACCUM → GAP → DRAIN → FLUSH → DONE → IDLE.
- IDLE: `cmd_ready`=1 and `busy`=0. A handshake (`cmd_valid && cmd_ready`) latches C and P and moves to FILL.
  - C = `cmd_num_cols`. C=0 is treated as 1; C>ARRAY_M is clamped to ARRAY_M.
  - P = `cmd_num_passes`. P=0 is treated as 1.
- `acc_num_cols` updates with the clamped C at the handshake and holds until the next handshake.
- FILL: lasts FILL_LAT cycles. With FILL_LAT=0 it is skipped and the FSM goes straight to ACCUM.
- ACCUM: `acc_on`=1 for exactly ON_LEN = P·DEPTH + C − 1 consecutive cycles. Passes run back to back with no gaps. The on-length counter is wide enough for the maximum ON_LEN with no overflow.
- GAP: one cycle with all controls low.
- DRAIN: `acc_drain`=1 for DEPTH cycles.
- FLUSH: lasts DRAIN_LAT cycles.
- `out_valid` is `acc_drain` delayed by DRAIN_LAT cycles. `out_last` marks the final `out_valid` cycle.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy` is high in every state except IDLE, including DONE.
- `cmd_valid` while busy is ignored and held off by `cmd_ready`=0. No back-pressure on the output: the consumer must accept every `out_valid` beat.

## Timing
- Reset values: all outputs 0 while `reset` is high (including `cmd_ready` and `acc_num_cols`); state = IDLE. `cmd_ready`=1 on the first cycle after `reset` falls.
- Reset mid-operation:
  - All outputs go to 0 at the next edge.
  - Any `out_valid` still in the DRAIN_LAT delay line is discarded.
  - No `done` pulse is produced.
- Take the handshake cycle as T, with F = FILL_LAT:
  - `acc_on` is high for cycles T+1+F … T+F+ON_LEN.
  - GAP is at T+F+ON_LEN+1.
  - `acc_drain` is high for T+F+ON_LEN+2 … T+F+ON_LEN+DEPTH+1.
  - `done` is high on the cycle after the last `out_valid`.
  - The next handshake is possible on the cycle after `done`.
- `acc_on` and `acc_drain` are never high in the same cycle.
- All outputs are registered.

## Configuration
- `ACC_CTRL_PERF_EN` defined:
  - `perf_cycles` counts cycles with `busy`=1 for the current or most recent command.
  - It clears to 0 at each handshake and saturates at 2^32−1.
  - It holds its value in IDLE and resets to 0.
- `ACC_CTRL_PERF_EN` undefined: the `perf_cycles` port and its counter are absent. All other behaviour is identical.

## Test plan
- Defaults, C=8, P=1, handshake at T=0:
  - `acc_on` high cycles 9–23 (15 cycles), GAP at 24, `acc_drain` high 25–32.
  - `out_valid` high 26–33, `out_last` at 33, `done` at 34, `cmd_ready` high at 35.
- C=3, P=4, FILL_LAT=0, DRAIN_LAT=0: `acc_on` high continuously for 34 cycles starting at T+1; `out_valid` is coincident with `acc_drain`.
- C=0, P=0: behaves exactly as C=1, P=1; `acc_num_cols`=1; `acc_on` high for 8 cycles. C=12 with ARRAY_M=8: `acc_num_cols`=8.
- `cmd_valid` held high throughout: a second command is accepted only on the cycle after `done`; exactly 8 `out_valid` beats per command.
- `reset` pulsed at cycle 15 of a C=8, P=1 run: all outputs 0 at cycle 16; no `done`; a fresh command then runs to full, correct completion.
- With `ACC_CTRL_PERF_EN`: the defaults run reads `perf_cycles`=34 after `done` and 0 after reset.
